// File: rtl/syn_fifo_core.sv
// Single-clock FIFO with registered read data, occupancy count and full/empty flags.
// d_depth must be a power of two >= 2 so the pointers wrap naturally.

module syn_fifo_core #(
    parameter int unsigned d_width = 8,
    parameter int unsigned d_depth = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               w_en,
    input  logic [d_width-1:0] w_data,
    input  logic               r_en,
    output logic [d_width-1:0] r_data,
    output logic               isEmpty,
    output logic               isFull
);

    localparam int unsigned AddrW = $clog2(d_depth);
    localparam int unsigned CntW  = AddrW + 1;

    localparam logic [CntW-1:0]  FullCount = CntW'(d_depth);
    localparam logic [AddrW-1:0] PtrOne    = AddrW'(1);
    localparam logic [CntW-1:0]  CntOne    = CntW'(1);

    logic [d_width-1:0] mem_q [d_depth];

    logic [AddrW-1:0]   wptr_q, wptr_d;
    logic [AddrW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [d_width-1:0] r_data_q, r_data_d;

    logic empty, full;
    logic wr_acc, rd_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCount);

    // A write while full is only accepted when a read frees the slot in the same cycle.
    assign wr_acc = w_en & ~n_rst & (~full | r_en);
    assign rd_acc = r_en & ~n_rst & ~empty;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        r_data_d = r_data_q;

        if (wr_acc) begin
            wptr_d = wptr_q + PtrOne;
        end

        if (rd_acc) begin
            rptr_d   = rptr_q + PtrOne;
            r_data_d = mem_q[rptr_q];
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            r_data_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            r_data_q <= r_data_d;
        end
    end

    // Storage is deliberately left unreset; stale words are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wptr_q] <= w_data;
        end
    end

    assign r_data  = r_data_q;
    assign isEmpty = empty;
    assign isFull  = full;

endmodule

// File: tb/tb_syn_fifo_core.sv
// Directed bench for syn_fifo_core: reset, fill, drain, wrap, simultaneous access, async reset.

module tb_syn_fifo_core;

    localparam int unsigned W = 8;
    localparam int unsigned D = 8;

    logic         clk;
    logic         n_rst;
    logic         w_en;
    logic [W-1:0] w_data;
    logic         r_en;
    logic [W-1:0] r_data;
    logic         isEmpty;
    logic         isFull;

    int tests_run;
    int tests_failed;

    syn_fifo_core #(
        .d_width(W),
        .d_depth(D)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .w_en   (w_en),
        .w_data (w_data),
        .r_en   (r_en),
        .r_data (r_data),
        .isEmpty(isEmpty),
        .isFull (isFull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        step();
        step();
        tests_run++;
        if (isEmpty !== 1'b1 || isFull !== 1'b0 || r_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_hold: empty=%b full=%b r_data=%h, want 1 0 00", isEmpty, isFull,
                     r_data);
        end
        n_rst = 1'b0;
        r_en  = 1'b1;
        step();
        r_en = 1'b0;
        tests_run++;
        if (isEmpty !== 1'b1 || r_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_read_empty: empty=%b r_data=%h, want 1 00", isEmpty, r_data);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            w_en   = 1'b1;
            w_data = 8'(i);
            step();
            tests_run++;
            if (isEmpty !== 1'b0 || isFull !== (i == 8)) begin
                tests_failed++;
                $display("FAIL fill_%0d: empty=%b full=%b, want 0 %b", i, isEmpty, isFull,
                         (i == 8));
            end
        end
        w_data = 8'd9;
        step();
        w_en = 1'b0;
        tests_run++;
        if (isFull !== 1'b1 || isEmpty !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_drop9: empty=%b full=%b, want 0 1", isEmpty, isFull);
        end
    endtask

    task automatic test_drain();
        r_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            tests_run++;
            if (r_data !== 8'(i) || isEmpty !== (i == 8) || isFull !== 1'b0) begin
                tests_failed++;
                $display("FAIL drain_%0d: r_data=%h empty=%b full=%b, want %h %b 0", i, r_data,
                         isEmpty, isFull, 8'(i), (i == 8));
            end
        end
        step();
        step();
        r_en = 1'b0;
        tests_run++;
        if (r_data !== 8'h08 || isEmpty !== 1'b1) begin
            tests_failed++;
            $display("FAIL drain_empty_hold: r_data=%h empty=%b, want 08 1", r_data, isEmpty);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            w_en   = 1'b1;
            w_data = 8'h10 + 8'(i);
            step();
        end
        w_en = 1'b0;
        r_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (r_data !== 8'h10 + 8'(i)) begin
                tests_failed++;
                $display("FAIL wrap_pre_%0d: r_data=%h, want %h", i, r_data, 8'h10 + 8'(i));
            end
        end
        r_en = 1'b0;
        tests_run++;
        if (isEmpty !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_pre_empty: empty=%b, want 1", isEmpty);
        end
        for (int i = 0; i < 8; i++) begin
            w_en   = 1'b1;
            w_data = 8'hA0 + 8'(i);
            step();
        end
        w_en = 1'b0;
        tests_run++;
        if (isFull !== 1'b1 || isEmpty !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_full: empty=%b full=%b, want 0 1", isEmpty, isFull);
        end
        r_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            tests_run++;
            if (r_data !== 8'hA0 + 8'(i) || isFull !== 1'b0 || isEmpty !== (i == 7)) begin
                tests_failed++;
                $display("FAIL wrap_read_%0d: r_data=%h empty=%b full=%b, want %h %b 0", i,
                         r_data, isEmpty, isFull, 8'hA0 + 8'(i), (i == 7));
            end
        end
        r_en = 1'b0;
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 8; i++) begin
            w_en   = 1'b1;
            w_data = 8'h30 + 8'(i);
            step();
        end
        w_data = 8'h55;
        r_en   = 1'b1;
        step();
        w_en = 1'b0;
        tests_run++;
        if (r_data !== 8'h30 || isFull !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_full: r_data=%h full=%b, want 30 1", r_data, isFull);
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            tests_run++;
            if (r_data !== ((i == 8) ? 8'h55 : 8'h30 + 8'(i)) || isEmpty !== (i == 8)) begin
                tests_failed++;
                $display("FAIL simul_full_drain_%0d: r_data=%h empty=%b, want %h %b", i, r_data,
                         isEmpty, (i == 8) ? 8'h55 : 8'h30 + 8'(i), (i == 8));
            end
        end
        r_en = 1'b0;
    endtask

    task automatic test_simul_empty();
        w_en   = 1'b1;
        r_en   = 1'b1;
        w_data = 8'h66;
        step();
        w_en = 1'b0;
        r_en = 1'b0;
        tests_run++;
        if (r_data !== 8'h55 || isEmpty !== 1'b0 || isFull !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_empty: r_data=%h empty=%b full=%b, want 55 0 0", r_data,
                     isEmpty, isFull);
        end
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        tests_run++;
        if (r_data !== 8'h66 || isEmpty !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_empty_single: r_data=%h empty=%b, want 66 1", r_data, isEmpty);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            w_en   = 1'b1;
            w_data = 8'hC0 + 8'(i);
            step();
        end
        w_en = 1'b0;
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        tests_run++;
        if (r_data !== 8'hC0) begin
            tests_failed++;
            $display("FAIL async_pre: r_data=%h, want c0", r_data);
        end
        #2;
        n_rst = 1'b1;
        #1;
        tests_run++;
        if (isEmpty !== 1'b1 || r_data !== 8'h00 || isFull !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_immediate: empty=%b full=%b r_data=%h, want 1 0 00", isEmpty,
                     isFull, r_data);
        end
        // Requests during reset must be ignored.
        w_en   = 1'b1;
        r_en   = 1'b1;
        w_data = 8'hEE;
        step();
        n_rst = 1'b0;
        w_en  = 1'b0;
        r_en  = 1'b0;
        tests_run++;
        if (isEmpty !== 1'b1 || r_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_ignore: empty=%b r_data=%h, want 1 00", isEmpty, r_data);
        end
        w_en   = 1'b1;
        w_data = 8'h99;
        step();
        w_en = 1'b0;
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        tests_run++;
        if (r_data !== 8'h99 || isEmpty !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_discard: r_data=%h empty=%b, want 99 1", r_data, isEmpty);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        n_rst        = 1'b1;
        w_en         = 1'b0;
        r_en         = 1'b0;
        w_data       = '0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul_full();
        test_simul_empty();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
